// File: rtl/hyper_frdram_sched.sv
`default_nettype none
// ============================================================================
// Module      : hyper_frdram_sched
// Description : Splits one long DRAM read job into mover-sized chunks, issues
//               them to hyper_mvblck_frdram, re-issues from the exact stop
//               word after an LSAB-full abrupt stop, and reports completion
//               with the delivered word count.
// Revision    : 1.0 - initial release
// ============================================================================
module hyper_frdram_sched #(
   parameter int MAX_CHUNK = 32,
   parameter int RETRY_GAP = 4
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        REQ_VALID,
   output logic        REQ_READY,
   input  logic [11:0] REQ_ADDRESS,
   input  logic [11:0] REQ_LEN,
   input  logic [1:0]  REQ_SECTION,
   input  logic [1:0]  REQ_DRAM_SEL,
   input  logic        ABORT,
   output logic        DONE,
   output logic [11:0] DONE_COUNT,
   output logic        DONE_ABORTED,
   input  logic        LSAB_0_FULL,
   input  logic        LSAB_1_FULL,
   input  logic        LSAB_2_FULL,
   input  logic        LSAB_3_FULL,
   output logic        MV_ISSUE,
   output logic [11:0] MV_START_ADDRESS,
   output logic [5:0]  MV_COUNT_REQ,
   output logic [1:0]  MV_SECTION,
   output logic [1:0]  MV_DRAM_SEL,
   input  logic        MV_WORKING,
   input  logic        MV_ABRUPT_STOP,
   input  logic [5:0]  MV_COUNT_SENT
);

   localparam logic [11:0] c_MAX_CHUNK12 = 12'(MAX_CHUNK);
   localparam logic [5:0]  c_MAX_CHUNK6  = 6'(MAX_CHUNK);
   localparam int          c_GAP_W       = $clog2(RETRY_GAP + 2);
   // Gap counter value seen in the last required not-full cycle
   localparam logic [c_GAP_W-1:0] c_GAP_LAST =
      c_GAP_W'((RETRY_GAP > 0) ? (RETRY_GAP - 1) : 0);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CHECK  = 3'd1,
      S_ROOM   = 3'd2,
      S_ISSUE  = 3'd3,
      S_WSTART = 3'd4,
      S_WEND   = 3'd5,
      S_ACCT   = 3'd6
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [11:0]        r_addr;
   logic [11:0]        r_rem;
   logic [11:0]        r_sent;
   logic [1:0]         r_section;
   logic [1:0]         r_dram_sel;
   logic               r_abort;
   logic               r_retry;
   logic               r_issued;
   logic               r_stop;
   logic [5:0]         r_cnt_sent;
   logic [5:0]         r_chunk;
   logic [c_GAP_W-1:0] r_gap;
   logic               r_done;
   logic [11:0]        r_done_count;
   logic               r_done_aborted;
   logic [11:0]        r_mv_addr;
   logic [5:0]         r_mv_count;
   logic [1:0]         r_mv_section;
   logic [1:0]         r_mv_dram_sel;

   logic               w_ready;
   logic               w_issue;
   logic               w_accept;
   logic               w_full;
   logic               w_abort;
   logic               w_gap_ok;
   logic [5:0]         w_chunk_calc;
   logic [11:0]        w_sent_ext;
   logic [11:0]        w_chunk_ext;
   logic [11:0]        w_progress;
   logic [11:0]        w_rem_next;
   logic [11:0]        w_sent_next;
   logic               w_finish;

   // Full flag of the section this job targets
   always_comb begin
      case (r_section)
         2'd0:    w_full = LSAB_0_FULL;
         2'd1:    w_full = LSAB_1_FULL;
         2'd2:    w_full = LSAB_2_FULL;
         default: w_full = LSAB_3_FULL;
      endcase
   end

   // Chunk sizing, word accounting and completion decision
   always_comb begin
      w_abort      = r_abort | ABORT;
      w_gap_ok     = (RETRY_GAP <= 1) || (r_gap >= c_GAP_LAST);
      w_chunk_calc = (r_rem < c_MAX_CHUNK12) ? r_rem[5:0] : c_MAX_CHUNK6;
      w_sent_ext   = {6'd0, r_cnt_sent};
      w_chunk_ext  = {6'd0, r_chunk};
      // A chunk that was never issued (abort before ISSUE, empty job) moves nothing
      if (!r_issued)
         w_progress = 12'd0;
      else if (r_stop && (w_sent_ext < w_chunk_ext))
         w_progress = w_sent_ext;
      else
         w_progress = w_chunk_ext;
      w_rem_next  = r_rem - w_progress;
      w_sent_next = r_sent + w_progress;
      w_finish    = (w_rem_next == 12'd0) || w_abort;
   end

   // Next-state decode and the single-cycle handshake outputs
   always_comb begin
      w_next  = r_state;
      w_ready = 1'b0;
      w_issue = 1'b0;
      case (r_state)
         S_IDLE: begin
            // Held low while DONE is showing, and while reset is asserted
            w_ready = RST && !r_done;
            if (REQ_VALID && w_ready)
               w_next = (REQ_LEN == 12'd0) ? S_ACCT : S_CHECK;
         end
         S_CHECK: begin
            w_next = w_abort ? S_ACCT : S_ROOM;
         end
         S_ROOM: begin
            if (w_abort)
               w_next = S_ACCT;
            else if (!w_full && (!r_retry || w_gap_ok))
               w_next = S_ISSUE;
         end
         S_ISSUE: begin
            w_issue = 1'b1;
            w_next  = S_WSTART;
         end
         S_WSTART: begin
            if (MV_WORKING)
               w_next = S_WEND;
         end
         S_WEND: begin
            if (!MV_WORKING)
               w_next = S_ACCT;
         end
         S_ACCT: begin
            w_next = w_finish ? S_IDLE : S_CHECK;
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign w_accept = (r_state == S_IDLE) && REQ_VALID && w_ready;

   // State register
   always_ff @(posedge CLK) begin
      if (!RST)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   // Job context, chunk bookkeeping and registered outputs
   always_ff @(posedge CLK) begin
      if (!RST) begin
         r_addr         <= 12'd0;
         r_rem          <= 12'd0;
         r_sent         <= 12'd0;
         r_section      <= 2'd0;
         r_dram_sel     <= 2'd0;
         r_abort        <= 1'b0;
         r_retry        <= 1'b0;
         r_issued       <= 1'b0;
         r_stop         <= 1'b0;
         r_cnt_sent     <= 6'd0;
         r_chunk        <= 6'd0;
         r_gap          <= '0;
         r_done         <= 1'b0;
         r_done_count   <= 12'd0;
         r_done_aborted <= 1'b0;
         r_mv_addr      <= 12'd0;
         r_mv_count     <= 6'd0;
         r_mv_section   <= 2'd0;
         r_mv_dram_sel  <= 2'd0;
      end else begin
         r_done <= 1'b0;
         // Sticky abort; cleared when a job is accepted or completes
         if ((r_state != S_IDLE) && ABORT)
            r_abort <= 1'b1;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_addr     <= REQ_ADDRESS;
                  r_rem      <= REQ_LEN;
                  r_sent     <= 12'd0;
                  r_section  <= REQ_SECTION;
                  r_dram_sel <= REQ_DRAM_SEL;
                  r_abort    <= 1'b0;
                  r_retry    <= 1'b0;
                  r_issued   <= 1'b0;
               end
            end
            S_CHECK: begin
               r_chunk <= w_chunk_calc;
               r_gap   <= '0;
            end
            S_ROOM: begin
               // Any full cycle restarts the retry gap
               if (w_full)
                  r_gap <= '0;
               else if (!w_gap_ok)
                  r_gap <= r_gap + c_GAP_W'(1);
               if (w_next == S_ISSUE) begin
                  r_mv_addr     <= r_addr;
                  r_mv_count    <= r_chunk - 6'd1;
                  r_mv_section  <= r_section;
                  r_mv_dram_sel <= r_dram_sel;
               end
            end
            S_ISSUE: begin
               r_issued <= 1'b1;
            end
            S_WEND: begin
               if (!MV_WORKING) begin
                  r_stop     <= MV_ABRUPT_STOP;
                  r_cnt_sent <= MV_COUNT_SENT;
               end
            end
            S_ACCT: begin
               r_addr   <= r_addr + w_progress;
               r_rem    <= w_rem_next;
               r_sent   <= w_sent_next;
               r_issued <= 1'b0;
               if (w_finish) begin
                  r_done         <= 1'b1;
                  r_done_count   <= w_sent_next;
                  r_done_aborted <= w_abort && (w_rem_next != 12'd0);
                  r_abort        <= 1'b0;
               end else begin
                  r_retry <= r_issued && r_stop;
               end
            end
            default: ;
         endcase
      end
   end

   assign REQ_READY        = w_ready;
   assign MV_ISSUE         = w_issue;
   assign DONE             = r_done;
   assign DONE_COUNT       = r_done_count;
   assign DONE_ABORTED     = r_done_aborted;
   assign MV_START_ADDRESS = r_mv_addr;
   assign MV_COUNT_REQ     = r_mv_count;
   assign MV_SECTION       = r_mv_section;
   assign MV_DRAM_SEL      = r_mv_dram_sel;

endmodule
`default_nettype wire

// File: tb/tb_hyper_frdram_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_hyper_frdram_sched
// Description : Bench for hyper_frdram_sched with a word-level mover model
//               and a job-level reference of expected issues and completion.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hyper_frdram_sched;

   localparam int MAX_CHUNK = 32;
   localparam int RETRY_GAP = 4;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        REQ_VALID, REQ_READY, ABORT, DONE, DONE_ABORTED;
   logic [11:0] REQ_ADDRESS, REQ_LEN, DONE_COUNT, MV_START_ADDRESS;
   logic [1:0]  REQ_SECTION, REQ_DRAM_SEL, MV_SECTION, MV_DRAM_SEL;
   logic [3:0]  lsab_full;
   logic        MV_ISSUE, MV_WORKING, MV_ABRUPT_STOP;
   logic [5:0]  MV_COUNT_REQ, MV_COUNT_SENT;

   hyper_frdram_sched #(.MAX_CHUNK(MAX_CHUNK), .RETRY_GAP(RETRY_GAP)) dut (
      .CLK(CLK), .RST(RST),
      .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
      .REQ_ADDRESS(REQ_ADDRESS), .REQ_LEN(REQ_LEN),
      .REQ_SECTION(REQ_SECTION), .REQ_DRAM_SEL(REQ_DRAM_SEL),
      .ABORT(ABORT), .DONE(DONE), .DONE_COUNT(DONE_COUNT), .DONE_ABORTED(DONE_ABORTED),
      .LSAB_0_FULL(lsab_full[0]), .LSAB_1_FULL(lsab_full[1]),
      .LSAB_2_FULL(lsab_full[2]), .LSAB_3_FULL(lsab_full[3]),
      .MV_ISSUE(MV_ISSUE), .MV_START_ADDRESS(MV_START_ADDRESS),
      .MV_COUNT_REQ(MV_COUNT_REQ), .MV_SECTION(MV_SECTION), .MV_DRAM_SEL(MV_DRAM_SEL),
      .MV_WORKING(MV_WORKING), .MV_ABRUPT_STOP(MV_ABRUPT_STOP), .MV_COUNT_SENT(MV_COUNT_SENT)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_errors = 0;

   // Job reference: words delivered so far define the next expected issue
   int cyc = 0;
   bit job_active = 0;
   int j_addr, j_len, j_sec, j_dsel;
   int delivered = 0, issues = 0, accept_cyc = 0, done_events = 0, last_done_count = 0;
   bit abort_seen = 0, prev_stopped = 0;
   int nf_run = 0;

   // Mover model state
   int m_phase = 0, m_cnt = 0, m_sent = 0, m_stop_at = -1, m_sec = 0, m_hold = 0;
   int full_timer [4];
   bit rand_stops = 0;
   int forced_k = -1, forced_hold = 10;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   // Mover model, LSAB flags and reference checks, all on the falling edge
   initial begin
      int exp_len;
      bit just_issued;
      for (int s = 0; s < 4; s++) full_timer[s] = 0;
      forever begin
         @(negedge CLK);
         cyc++;
         if (!RST) begin
            job_active = 0; m_phase = 0;
            MV_WORKING = 0; MV_ABRUPT_STOP = 0; MV_COUNT_SENT = 0;
            lsab_full = 4'd0;
            for (int s = 0; s < 4; s++) full_timer[s] = 0;
            continue;
         end
         if (REQ_VALID && REQ_READY) begin
            job_active = 1; j_addr = int'(REQ_ADDRESS); j_len = int'(REQ_LEN);
            j_sec = int'(REQ_SECTION); j_dsel = int'(REQ_DRAM_SEL);
            delivered = 0; issues = 0; accept_cyc = cyc;
            abort_seen = 0; prev_stopped = 0; nf_run = 0;
         end
         if (ABORT && job_active) abort_seen = 1;
         just_issued = 0;
         if (MV_ISSUE) begin
            check_eq("issue_allowed", 32'({job_active, m_phase == 0, !abort_seen}), 32'b111);
            if (job_active && m_phase == 0 && !abort_seen) begin
               exp_len = j_len - delivered;
               if (exp_len > MAX_CHUNK) exp_len = MAX_CHUNK;
               check_eq("issue_addr", 32'(MV_START_ADDRESS), 32'((j_addr + delivered) % 4096));
               check_eq("issue_count", 32'(MV_COUNT_REQ), 32'(exp_len - 1));
               check_eq("issue_sec_dsel", 32'({MV_SECTION, MV_DRAM_SEL}), 32'(j_sec * 4 + j_dsel));
               if (prev_stopped)
                  check_eq("retry_gap", 32'(nf_run), 32'(RETRY_GAP));
               else
                  check_eq("first_room_free", 32'(nf_run >= 1), 32'd1);
               issues++;
               m_cnt = int'(MV_COUNT_REQ) + 1; m_sent = 0; m_sec = j_sec;
               m_phase = 1; just_issued = 1; m_stop_at = -1;
               if (forced_k >= 0 && forced_k < m_cnt) begin
                  m_stop_at = forced_k; m_hold = forced_hold; forced_k = -1;
               end else if (rand_stops && $urandom_range(0, 2) == 0) begin
                  m_stop_at = int'($urandom_range(0, m_cnt - 1));
                  m_hold = int'($urandom_range(6, 12));
               end
            end
         end
         if (DONE) begin
            check_eq("done_in_job", 32'(job_active), 32'd1);
            check_eq("done_count", 32'(DONE_COUNT), 32'(abort_seen ? delivered : j_len));
            check_eq("done_aborted", 32'(DONE_ABORTED), 32'(abort_seen && delivered < j_len));
            check_eq("ready_vs_done", 32'(REQ_READY), 32'd0);
            if (j_len == 0) check_eq("empty_done_latency", 32'(cyc - accept_cyc), 32'd2);
            last_done_count = int'(DONE_COUNT);
            done_events++;
            job_active = 0;
         end
         for (int s = 0; s < 4; s++) begin
            if (full_timer[s] > 0) begin
               full_timer[s]--;
               if (full_timer[s] == 0) lsab_full[s] = 1'b0;
            end
         end
         if (!just_issued) begin
            if (m_phase == 1) begin
               MV_WORKING = 1; MV_ABRUPT_STOP = 0; m_phase = 2;
            end else if (m_phase == 2) begin
               if (m_sent == m_stop_at) begin
                  MV_WORKING = 0; MV_ABRUPT_STOP = 1; MV_COUNT_SENT = 6'(m_sent);
                  lsab_full[m_sec] = 1'b1; full_timer[m_sec] = m_hold;
                  m_phase = 0; prev_stopped = 1;
               end else begin
                  delivered++; m_sent++;
                  if (m_sent == m_cnt) begin
                     MV_WORKING = 0; MV_ABRUPT_STOP = 0; MV_COUNT_SENT = 6'(m_cnt);
                     m_phase = 0; prev_stopped = 0;
                  end
               end
            end
         end
         if (job_active) nf_run = lsab_full[j_sec] ? 0 : nf_run + 1;
      end
   end

   task automatic tick();
      @(posedge CLK); #2;
   endtask

   task automatic check_reset_outputs();
      check_eq("rst_ready", 32'(REQ_READY), 32'd0);
      check_eq("rst_done", 32'({DONE, DONE_COUNT, DONE_ABORTED}), 32'd0);
      check_eq("rst_mv", 32'({MV_ISSUE, MV_START_ADDRESS, MV_COUNT_REQ, MV_SECTION, MV_DRAM_SEL}), 32'd0);
   endtask

   task automatic send_req(input int addr, input int len, input int sec, input int dsel);
      int t = 0;
      while (!REQ_READY && t < 50) begin tick(); t++; end
      check_eq("ready_wait", 32'(REQ_READY), 32'd1);
      REQ_VALID = 1; REQ_ADDRESS = 12'(addr); REQ_LEN = 12'(len);
      REQ_SECTION = 2'(sec); REQ_DRAM_SEL = 2'(dsel);
      tick();
      REQ_VALID = 0; REQ_ADDRESS = 12'($urandom); REQ_LEN = 12'($urandom);
      REQ_SECTION = 2'($urandom); REQ_DRAM_SEL = 2'($urandom);
   endtask

   // abort_mode: 0 none, 1 while the mover is working, 2 while the section is full
   task automatic run_job(input int addr, input int len, input int sec, input int dsel,
                          input int abort_mode, input int exp_issues, input int exp_count);
      int t;
      int d0 = done_events;
      send_req(addr, len, sec, dsel);
      if (abort_mode != 0) begin
         t = 0;
         while (t < 400 && done_events == d0 &&
                !((abort_mode == 1 && m_phase == 2) ||
                  (abort_mode == 2 && lsab_full[sec] && full_timer[sec] > 2))) begin
            tick(); t++;
         end
         ABORT = 1; tick(); ABORT = 0;
      end
      t = 0;
      while (done_events == d0 && t < (len + 10) * 30 + 400) begin tick(); t++; end
      check_eq("done_seen", 32'(done_events != d0), 32'd1);
      if (exp_issues >= 0) check_eq("issue_total", 32'(issues), 32'(exp_issues));
      if (exp_count >= 0) check_eq("job_count", 32'(last_done_count), 32'(exp_count));
      repeat (2) tick();
   endtask

   initial begin
      int d0, t, len;
      REQ_VALID = 0; REQ_ADDRESS = 0; REQ_LEN = 0; REQ_SECTION = 0; REQ_DRAM_SEL = 0;
      ABORT = 0; lsab_full = 4'd0;
      MV_WORKING = 0; MV_ABRUPT_STOP = 0; MV_COUNT_SENT = 0;
      RST = 0;
      repeat (3) tick();
      check_reset_outputs();
      RST = 1; #1;
      check_eq("ready_after_rst", 32'(REQ_READY), 32'd1);
      tick();

      // Plain three-chunk job
      run_job(12'h010, 80, 1, 2, 0, 3, 80);
      // Abrupt stop after 7 words, flag held 10 cycles
      forced_k = 7; forced_hold = 10;
      run_job(12'h100, 20, 2, 1, 0, 2, 20);
      // Address wrap
      run_job(12'hFF0, 40, 3, 3, 0, 2, 40);
      // Empty job
      run_job(12'h123, 0, 0, 1, 0, 0, 0);
      // Abort during the first chunk
      run_job(12'h200, 100, 0, 0, 1, 1, 32);
      // Abort while waiting for room after a stop
      forced_k = 5; forced_hold = 12;
      run_job(12'h300, 50, 2, 0, 2, 1, 5);

      // Reset during the second chunk, then a clean job
      d0 = done_events;
      send_req(12'h400, 100, 0, 1);
      t = 0;
      while (!(issues == 2 && m_phase == 2) && t < 500) begin tick(); t++; end
      check_eq("reach_chunk2", 32'(issues == 2 && m_phase == 2), 32'd1);
      RST = 0;
      tick();
      check_reset_outputs();
      tick();
      RST = 1;
      check_eq("no_done_on_rst", 32'(done_events), 32'(d0));
      tick();
      run_job(12'h7FF, 45, 1, 3, 0, 2, 45);

      // Randomized jobs with random stops and occasional aborts
      rand_stops = 1;
      for (int i = 0; i < 20; i++) begin
         len = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 70)) : int'($urandom_range(0, 300));
         run_job(int'($urandom_range(0, 4095)), len, int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), ($urandom_range(0, 4) == 0) ? 1 : 0, -1, -1);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
